aggregator_ctrl: RTL and testbench



---
 rtl/aggregator_ctrl.sv | 114 +++++++++++
 tb/tb_aggregator_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/aggregator_ctrl.sv
// Sequencer for the CIM partial-sum Aggregator: counts passes per filter, gates/clears
// the Aggregator and strobes each finished sum into the result FIFO. Optional AGG_CTRL_PERF_EN adds a stall counter.
module aggregator_ctrl #(
    parameter int MAX_PASSES = 8,
    parameter int JOB_W      = 8,
    parameter int CNT_W      = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_passes,
    input  logic [JOB_W-1:0] cfg_jobs,
    output logic             busy,
    input  logic             psum_valid,
    output logic             psum_ready,
    output logic             agg_in_en,
    output logic             agg_clear,
    input  logic             res_full,
    output logic             res_we,
    output logic             res_last,
    output logic             done
`ifdef AGG_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    // state | meaning
    // IDLE  | Aggregator held clear, waiting for start
    // ACCUM | accepting partial sums, flushing one result per filter
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   pass_cnt, passes_r;
    logic [JOB_W-1:0]   job_cnt, jobs_r;
    logic               last_pass;
    logic               acc;

    always_comb begin
        state_nx   = state;
        last_pass  = 1'b0;
        acc        = 1'b0;
        psum_ready = 1'b0;
        agg_in_en  = 1'b0;
        agg_clear  = 1'b1;
        res_we     = 1'b0;
        res_last   = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = ACCUM;
            end
            ACCUM: begin
                last_pass  = (pass_cnt == passes_r);
                // Only the flushing pass needs FIFO room; earlier passes never stall.
                psum_ready = !last_pass || !res_full;
                acc        = psum_valid && psum_ready;
                agg_in_en  = acc;
                agg_clear  = acc && last_pass;
                res_we     = acc && last_pass;
                res_last   = res_we && (job_cnt == jobs_r);
                if (res_last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pass_cnt <= '0;
            job_cnt  <= '0;
            passes_r <= '0;
            jobs_r   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ACCUM);
            done  <= res_last;
            if (state == IDLE) begin
                if (start) begin
                    passes_r <= cfg_passes;
                    jobs_r   <= cfg_jobs;
                    pass_cnt <= '0;
                    job_cnt  <= '0;
                end
            end else begin
                if (res_we) begin
                    pass_cnt <= '0;
                    if (!res_last)
                        job_cnt <= job_cnt + JOB_W'(1);
                end else if (acc) begin
                    pass_cnt <= pass_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef AGG_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == IDLE) begin
            if (start)
                stall_cycles <= '0;
        end else if (psum_valid && !psum_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aggregator_ctrl.sv
// Directed bench for aggregator_ctrl with a behavioural Aggregator buffer model.
// Build with AGG_CTRL_PERF_EN defined to also exercise stall_cycles.
module tb_aggregator_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] cfg_passes;
    logic [7:0] cfg_jobs;
    logic       busy;
    logic       psum_valid;
    logic       psum_ready;
    logic       agg_in_en;
    logic       agg_clear;
    logic       res_full;
    logic       res_we;
    logic       res_last;
    logic       done;
`ifdef AGG_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    aggregator_ctrl #(.MAX_PASSES(8), .JOB_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_passes(cfg_passes), .cfg_jobs(cfg_jobs),
        .busy(busy), .psum_valid(psum_valid), .psum_ready(psum_ready), .agg_in_en(agg_in_en),
        .agg_clear(agg_clear), .res_full(res_full), .res_we(res_we), .res_last(res_last),
        .done(done)
`ifdef AGG_CTRL_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Aggregator model: output = buffer + gated input; clear zeroes the buffer at the edge.
    logic [15:0] agg_buf = '0;
    logic [15:0] o_out;
    logic        o_ready, o_en, o_clr, o_we, o_last;
    int          we_cnt, last_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one cycle, samples combinational outputs before the edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic f, input logic s);
        psum_valid = v;
        res_full   = f;
        start      = s;
        #1;
        o_ready = psum_ready;
        o_en    = agg_in_en;
        o_clr   = agg_clear;
        o_we    = res_we;
        o_last  = res_last;
        o_out   = agg_buf + (agg_in_en ? 16'(d) : 16'd0);
        if (res_we) begin
            we_cnt++;
            if (res_last) last_cnt++;
        end
        @(posedge clk);
        agg_buf = o_clr ? 16'd0 : o_out;
        @(negedge clk);
        psum_valid = 1'b0;
        start      = 1'b0;
        res_full   = 1'b0;
    endtask

    task automatic begin_run(input logic [2:0] p, input logic [7:0] j);
        cfg_passes = p;
        cfg_jobs   = j;
        we_cnt     = 0;
        last_cnt   = 0;
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        cfg_passes = 3'd0;
        cfg_jobs   = 8'd0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_passes = '0; cfg_jobs = '0;
        psum_valid = 1'b0; res_full = 1'b0;
        we_cnt = 0; last_cnt = 0;
        @(negedge clk);
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        cyc(1'b1, 8'd0, 1'b0, 1'b1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        #1;
        chk("rst_ready", 32'(psum_ready), 32'd0);
        chk("rst_in_en", 32'(agg_in_en), 32'd0);
        chk("rst_clear", 32'(agg_clear), 32'd1);
        chk("rst_we", 32'(res_we), 32'd0);
        chk("rst_last", 32'(res_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 8 passes, one job, psums 1..8 -> 36
        begin_run(3'd7, 8'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 7; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("t1_no_early_we", 32'(we_cnt), 32'd0);
        cyc(1'b1, 8'd8, 1'b0, 1'b0);
        chk("t1_we", 32'(o_we), 32'd1);
        chk("t1_last", 32'(o_last), 32'd1);
        chk("t1_sum", 32'(o_out), 32'd36);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_off", 32'(busy), 32'd0);
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // single pass, four jobs
        begin_run(3'd0, 8'd3);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(20 + i), 1'b0, 1'b0);
            chk("t2_we", 32'(o_we), 32'd1);
            chk("t2_clear", 32'(o_clr), 32'd1);
            chk("t2_last", 32'(o_last), (i == 3) ? 32'd1 : 32'd0);
            chk("t2_sum", 32'(o_out), 32'(20 + i));
        end
        chk("t2_done", 32'(done), 32'd1);

        // 4 passes with valid gaps: 5+6+7+8 = 26
        begin_run(3'd3, 8'd0);
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 1) begin
                cyc(1'b0, 8'd99, 1'b0, 1'b0);
                chk("t3_gap_en", 32'(o_en), 32'd0);
                chk("t3_gap_clr", 32'(o_clr), 32'd0);
            end else begin
                cyc(1'b1, 8'(5 + i / 2), 1'b0, 1'b0);
                chk("t3_en", 32'(o_en), 32'd1);
            end
        end
        chk("t3_we", 32'(o_we), 32'd1);
        chk("t3_sum", 32'(o_out), 32'd26);

        // stall on the last pass for 5 cycles: 3+4 = 7
        begin_run(3'd1, 8'd0);
        cyc(1'b1, 8'd3, 1'b1, 1'b0);
        chk("t4_first_ready", 32'(o_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'd4, 1'b1, 1'b0);
            chk("t4_stall_ready", 32'(o_ready), 32'd0);
            chk("t4_stall_en", 32'(o_en), 32'd0);
        end
        chk("t4_stall_no_we", 32'(we_cnt), 32'd0);
        chk("t4_buf_held", 32'(agg_buf), 32'd3);
        cyc(1'b1, 8'd4, 1'b0, 1'b0);
        chk("t4_we", 32'(o_we), 32'd1);
        chk("t4_sum", 32'(o_out), 32'd7);
`ifdef AGG_CTRL_PERF_EN
        chk("t4_stall_cycles", stall_cycles, 32'd5);
`endif

        // abort mid-run with reset, then 10 x 8 = 80
        begin_run(3'd7, 8'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'd2, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        begin_run(3'd7, 8'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'd10, 1'b0, 1'b0);
        chk("t5_we_cnt", 32'(we_cnt), 32'd1);
        chk("t5_sum", 32'(o_out), 32'd80);

        // start during ACCUM with different config is ignored
        begin_run(3'd2, 8'd1);
        cyc(1'b1, 8'd1, 1'b0, 1'b0);
        cfg_passes = 3'd0;
        cfg_jobs   = 8'd0;
        cyc(1'b1, 8'd1, 1'b0, 1'b1);
        chk("t6_no_we", 32'(we_cnt), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'd1, 1'b0, 1'b0);
        chk("t6_we_cnt", 32'(we_cnt), 32'd2);
        chk("t6_last_cnt", 32'(last_cnt), 32'd1);
        chk("t6_done", 32'(done), 32'd1);

        // maximum job count: 256 single-pass filters
        begin_run(3'd0, 8'd255);
        for (int i = 0; i < 256; i++) cyc(1'b1, 8'd1, 1'b0, 1'b0);
        chk("t7_we_cnt", 32'(we_cnt), 32'd256);
        chk("t7_last_cnt", 32'(last_cnt), 32'd1);
        chk("t7_last_final", 32'(o_last), 32'd1);
        chk("t7_done", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
